// File: rtl/updn_bounded_counter.sv
// Bounded up/down counter with variable step, wrap or saturate mode,
// synchronous load, clamp on a lowered bound, and overflow/underflow flags.
module updn_bounded_counter #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              up_count,
    input  logic              down_count,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      max_val,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [N-1:0]      load_val,
    input  logic              clr_flags,
    output logic [N-1:0]      q,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    output logic              at_max,
    output logic              at_min
);

    localparam int W = N + 1;

    logic [N-1:0] q_q, q_d;
    logic         tc_up_q, tc_up_d;
    logic         tc_dn_q, tc_dn_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic [W-1:0] step_x;
    logic [W-1:0] q_x;
    logic [W-1:0] max_x;
    logic [W-1:0] lim_x;
    logic [W-1:0] sum_x;
    logic [W-1:0] up_wrap_x;
    logic [W-1:0] dn_base_x;
    logic [W-1:0] dn_wrap_x;
    logic         cnt_up;
    logic         cnt_dn;
    logic         ovf_ev;
    logic         unf_ev;

    // Widened operands; lim_x = max_val+1 is the wrap modulus.
    always_comb begin
        step_x    = {{(W-STEP_W){1'b0}}, step};
        q_x       = {1'b0, q_q};
        max_x     = {1'b0, max_val};
        lim_x     = max_x + W'(1);
        sum_x     = q_x + step_x;
        up_wrap_x = sum_x - lim_x;
        dn_base_x = q_x + lim_x;
        dn_wrap_x = dn_base_x - step_x;
        cnt_up    = enable & up_count & ~down_count & (step != '0);
        cnt_dn    = enable & down_count & ~up_count & (step != '0);
    end

    // Next counter value and event detection: load, clamp, count, hold.
    always_comb begin
        q_d    = q_q;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (load) begin
            q_d = (load_val > max_val) ? max_val : load_val;
        end else if (q_q > max_val) begin
            q_d = max_val;
        end else if (cnt_up) begin
            if (sum_x <= max_x) begin
                q_d = sum_x[N-1:0];
            end else begin
                ovf_ev = 1'b1;
                if (sat_mode) begin
                    q_d = max_val;
                end else if (up_wrap_x <= max_x) begin
                    q_d = up_wrap_x[N-1:0];
                end else begin
                    q_d = '0;
                end
            end
        end else if (cnt_dn) begin
            if (step_x <= q_x) begin
                q_d = q_q - step_x[N-1:0];
            end else begin
                unf_ev = 1'b1;
                if (sat_mode) begin
                    q_d = '0;
                end else if (step_x <= lim_x) begin
                    q_d = dn_wrap_x[N-1:0];
                end else begin
                    q_d = max_val;
                end
            end
        end
    end

    // Event pulses and sticky flags; a same-cycle event beats clr_flags.
    always_comb begin
        tc_up_d = ovf_ev;
        tc_dn_d = unf_ev;
        ovf_d   = ovf_ev | (ovf_q & ~clr_flags);
        unf_d   = unf_ev | (unf_q & ~clr_flags);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '0;
            tc_up_q <= 1'b0;
            tc_dn_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            tc_up_q <= tc_up_d;
            tc_dn_q <= tc_dn_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Outputs; bound indicators are combinational on q and max_val.
    always_comb begin
        q          = q_q;
        tc_up      = tc_up_q;
        tc_dn      = tc_dn_q;
        ovf_sticky = ovf_q;
        unf_sticky = unf_q;
        at_max     = (q_q == max_val);
        at_min     = (q_q == '0);
    end

endmodule

// File: tb/tb_updn_bounded_counter.sv
// Randomized and directed bench for updn_bounded_counter against an
// integer reference model of the counting rules.
module tb_updn_bounded_counter;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              up_count;
    logic              down_count;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      max_val;
    logic              sat_mode;
    logic              load;
    logic [N-1:0]      load_val;
    logic              clr_flags;
    logic [N-1:0]      q;
    logic              tc_up;
    logic              tc_dn;
    logic              ovf_sticky;
    logic              unf_sticky;
    logic              at_max;
    logic              at_min;

    int checks = 0;
    int errors = 0;

    int mq, mtu, mtd, mo, mu;

    updn_bounded_counter #(.N(N), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .up_count   (up_count),
        .down_count (down_count),
        .step       (step),
        .max_val    (max_val),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_val   (load_val),
        .clr_flags  (clr_flags),
        .q          (q),
        .tc_up      (tc_up),
        .tc_dn      (tc_dn),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; mtu = 0; mtd = 0; mo = 0; mu = 0;
    endtask

    // Reference: apply one clock edge using the currently driven inputs.
    task automatic model_edge();
        int mx, st, s, r;
        mx  = int'(max_val);
        st  = int'(step);
        mtu = 0;
        mtd = 0;
        if (load) begin
            mq = (int'(load_val) > mx) ? mx : int'(load_val);
        end else if (mq > mx) begin
            mq = mx;
        end else if (enable && (up_count != down_count) && st != 0) begin
            if (up_count) begin
                s = mq + st;
                if (s <= mx) mq = s;
                else begin
                    mtu = 1;
                    r = s - (mx + 1);
                    mq = sat_mode ? mx : ((r <= mx) ? r : 0);
                end
            end else begin
                if (st <= mq) mq = mq - st;
                else begin
                    mtd = 1;
                    if (sat_mode) mq = 0;
                    else mq = (st <= mx + 1) ? (mq + mx + 1 - st) : mx;
                end
            end
        end
        mo = (mtu || (mo && !clr_flags)) ? 1 : 0;
        mu = (mtd || (mu && !clr_flags)) ? 1 : 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"}, int'(q), mq);
        check({tag, ".tc_up"}, int'(tc_up), mtu);
        check({tag, ".tc_dn"}, int'(tc_dn), mtd);
        check({tag, ".ovf"}, int'(ovf_sticky), mo);
        check({tag, ".unf"}, int'(unf_sticky), mu);
        check({tag, ".at_max"}, int'(at_max), (mq == int'(max_val)) ? 1 : 0);
        check({tag, ".at_min"}, int'(at_min), (mq == 0) ? 1 : 0);
    endtask

    // One clock edge; inputs were set between edges, checked 1 after.
    task automatic cyc(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_model(tag);
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = N'(v);
        cyc("load");
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; up_count = 1'b0; down_count = 1'b0;
        step = '0; max_val = '0; sat_mode = 1'b0; load = 1'b0;
        load_val = '0; clr_flags = 1'b0;
        model_reset();
        #3;
        check("rst.q", int'(q), 0);
        check("rst.at_max0", int'(at_max), 1);
        check("rst.at_min", int'(at_min), 1);
        check("rst.flags", int'({tc_up, tc_dn, ovf_sticky, unf_sticky}), 0);
        max_val = 8'd255;
        #1;
        check("rst.at_max255", int'(at_max), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of counting.
        enable = 1'b1; up_count = 1'b1; step = 4'd1;
        repeat (5) cyc("mid");
        check("mid.q5", int'(q), 5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("mid_rst");
        #1;
        rst = 1'b0;
        cyc("resume");
        check("resume.q1", int'(q), 1);

        // Wrap up and down.
        enable = 1'b0; up_count = 1'b0; max_val = 8'd9; sat_mode = 1'b0;
        step = 4'd3;
        do_load(8);
        enable = 1'b1; up_count = 1'b1;
        cyc("wrap_up");
        check("wrap_up.q", int'(q), 1);
        check("wrap_up.tc", int'(tc_up), 1);
        check("wrap_up.ovf", int'(ovf_sticky), 1);
        up_count = 1'b0; down_count = 1'b1;
        cyc("wrap_dn");
        check("wrap_dn.q", int'(q), 8);
        check("wrap_dn.tc", int'(tc_dn), 1);
        check("wrap_dn.unf", int'(unf_sticky), 1);

        // Saturate at both bounds.
        enable = 1'b0; down_count = 1'b0; sat_mode = 1'b1;
        do_load(8);
        enable = 1'b1; up_count = 1'b1;
        cyc("sat_up1");
        check("sat_up1.q", int'(q), 9);
        check("sat_up1.tc", int'(tc_up), 1);
        cyc("sat_up2");
        check("sat_up2.q", int'(q), 9);
        check("sat_up2.tc", int'(tc_up), 1);
        enable = 1'b0; up_count = 1'b0;
        do_load(2);
        enable = 1'b1; down_count = 1'b1;
        cyc("sat_dn");
        check("sat_dn.q", int'(q), 0);
        check("sat_dn.tc", int'(tc_dn), 1);

        // Load limits, load priority, clamp on lowered bound.
        enable = 1'b0; down_count = 1'b0;
        do_load(200);
        check("load_big.q", int'(q), 9);
        enable = 1'b1; up_count = 1'b1;
        do_load(5);
        check("load_prio.q", int'(q), 5);
        enable = 1'b0; up_count = 1'b0;
        do_load(7);
        max_val = 8'd4;
        cyc("clamp");
        check("clamp.q", int'(q), 4);
        check("clamp.tc", int'({tc_up, tc_dn}), 0);

        // Hold conditions.
        enable = 1'b1; up_count = 1'b1; down_count = 1'b1;
        cyc("hold_both");
        check("hold_both.q", int'(q), 4);
        enable = 1'b0; down_count = 1'b0;
        cyc("hold_en");
        check("hold_en.q", int'(q), 4);
        enable = 1'b1; step = 4'd0;
        cyc("hold_step0");
        check("hold_step0.q", int'(q), 4);
        check("hold_step0.tc", int'(tc_up), 0);

        // Sticky clear, and event winning over clear.
        enable = 1'b0; clr_flags = 1'b1;
        cyc("clr");
        check("clr.flags", int'({ovf_sticky, unf_sticky}), 0);
        enable = 1'b1; step = 4'd3;
        cyc("clr_ovf");
        check("clr_ovf.ovf", int'(ovf_sticky), 1);
        clr_flags = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: max_val = 8'd255;
                    1: max_val = 8'd0;
                    2: max_val = N'($urandom_range(1, 12));
                    default: max_val = N'($urandom);
                endcase
            end
            if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
            enable     = ($urandom_range(0, 3) != 0);
            up_count   = 1'($urandom);
            down_count = 1'($urandom);
            step       = STEP_W'($urandom);
            load       = ($urandom_range(0, 15) == 0);
            load_val   = N'($urandom);
            clr_flags  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_model("rnd_rst");
                rst = 1'b0;
            end
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
